hist_update_ctrl: RTL

Sequencer for the bias-free neural predictor's dual-copy history registers: the branch-address history and the folded-outcome history. It tracks in-flight predicted branches in a FIFO and generates the speculative (en_1) and commit (en_2) strobes with their update data. After every resolution it replays surviving in-flight predictions, because a commit overwrites the speculative copy with the pre-commit true copy. It sits between the fetch-stage predictor and the EX-stage branch resolution.

---
 rtl/hist_update_ctrl_pkg.sv | 19 +
 rtl/hist_update_ctrl_inflight_fifo.sv | 53 +++++
 rtl/hist_update_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hist_update_ctrl_pkg.sv
// Shared types for the history-register update sequencer.
// Entry layout is {addr, dir}; the FSM has four states.
package hist_update_ctrl_pkg;

  localparam int HIST_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    FIX    = 2'd2,
    REPLAY = 2'd3
  } state_t;

  typedef struct packed {
    logic [HIST_ADDR_W-1:0] addr;
    logic                   dir;
  } entry_t;

endpackage

// File: rtl/hist_update_ctrl_inflight_fifo.sv
// In-flight branch FIFO with flush and a random-read port
// used to replay surviving entries after a resolution.
module hist_inflight_fifo #(
  parameter  int W     = 11,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  input  logic [PW-1:0] rd_ptr,
  output logic [W-1:0]  rd_data,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0] mem [DEPTH];

  assign head_data = mem[head];
  assign rd_data   = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // A flush lands tail on the post-pop head so nothing survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= head + PW'(pop);
      tail  <= head + PW'(pop);
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/hist_update_ctrl.sv
// Speculative/commit strobe sequencer for the dual-copy
// branch-address and folded-outcome history registers.
module hist_update_ctrl
  import hist_update_ctrl_pkg::*;
#(
  parameter  int ADDR_W = HIST_ADDR_W,
  parameter  int DEPTH  = 8,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] pred_addr,
  input  logic              pred_dir,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_dir,
  output logic              spec_en,
  output logic [ADDR_W-1:0] spec_addr,
  output logic              spec_dir,
  output logic              true_en,
  output logic [ADDR_W-1:0] true_addr,
  output logic              true_dir,
  output logic              mispredict,
  output logic [CW-1:0]     inflight_cnt
);

  state_t        state;
  entry_t        lat;
  entry_t        head_e;
  entry_t        rd_e;
  entry_t        push_e;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          full;
  logic          empty;
  logic          take_pred;
  logic          take_res;
  logic          mis;

  assign res_ready  = rst && (state == IDLE) && !empty;
  assign pred_ready = rst && (state == IDLE) && !full
                      && !(res_valid && res_ready);
  assign take_pred  = pred_valid && pred_ready;
  assign take_res   = res_valid && res_ready;
  assign mis        = (res_dir != head_e.dir);
  assign push_e     = '{addr: pred_addr, dir: pred_dir};
  assign rd_ptr     = (state == FIX) ? head_ptr : rptr;

  hist_inflight_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (take_pred),
    .push_data (push_e),
    .pop       (take_res),
    .flush     (take_res && mis),
    .head_data (head_e),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_e),
    .head      (head_ptr),
    .tail      (tail_ptr),
    .count     (inflight_cnt),
    .full      (full),
    .empty     (empty)
  );

  // Strobes are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat        <= '0;
      rptr       <= '0;
      spec_en    <= 1'b0;
      spec_addr  <= '0;
      spec_dir   <= 1'b0;
      true_en    <= 1'b0;
      true_addr  <= '0;
      true_dir   <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      spec_en    <= 1'b0;
      true_en    <= 1'b0;
      mispredict <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_res) begin
            true_en    <= 1'b1;
            true_addr  <= head_e.addr;
            true_dir   <= res_dir;
            mispredict <= mis;
            lat        <= '{addr: head_e.addr, dir: res_dir};
            state      <= COMMIT;
          end else if (take_pred) begin
            spec_en   <= 1'b1;
            spec_addr <= pred_addr;
            spec_dir  <= pred_dir;
          end
        end
        COMMIT: begin
          spec_en   <= 1'b1;
          spec_addr <= lat.addr;
          spec_dir  <= lat.dir;
          state     <= FIX;
        end
        FIX: begin
          if (empty) begin
            state <= IDLE;
          end else begin
            spec_en   <= 1'b1;
            spec_addr <= rd_e.addr;
            spec_dir  <= rd_e.dir;
            rptr      <= head_ptr + PW'(1);
            state     <= REPLAY;
          end
        end
        REPLAY: begin
          if (rptr == tail_ptr) begin
            state <= IDLE;
          end else begin
            spec_en   <= 1'b1;
            spec_addr <= rd_e.addr;
            spec_dir  <= rd_e.dir;
            rptr      <= rptr + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
